// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: round-robin whole-packet AXI-Stream merge with stall timeout,
// sticky timeout flags and per-channel completed-packet counters.
module axis_frame_arbiter #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int TO_W = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [TO_W-1:0]          timeout_cyc,
  input  logic                     err_clr,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [KEEP_W-1:0]        m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [CH_W-1:0]          m_axis_tid,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [CH_W-1:0]          grant_ch,
  output logic                     busy,
  output logic [NUM_CH-1:0]        timeout_err,
  output logic [NUM_CH*32-1:0]     pkt_cnt
);
  typedef enum logic [1:0] {IDLE, XFER, TERM, FLUSH} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [KEEP_W-1:0] ch_keep [NUM_CH];
  logic [31:0] cnt_q [NUM_CH];
  logic [DATA_W-1:0] sk_data [2];
  logic [KEEP_W-1:0] sk_keep [2];
  logic [CH_W-1:0] sk_id [2];
  logic [1:0] sk_last, sk_cnt;
  logic sk_wr, sk_rd;
  logic [CH_W-1:0] ptr, pick, cand;
  logic [TO_W-1:0] to_cnt;
  logic hit, full, push, pop, sel_valid, sel_last, acc, to_hit, pkt_end;
  logic [DATA_W-1:0] push_data;
  logic [KEEP_W-1:0] push_keep;

  function automatic logic [CH_W-1:0] wrap(input logic [CH_W:0] v);
    return (v >= (CH_W+1)'(NUM_CH)) ? CH_W'(v - (CH_W+1)'(NUM_CH)) : CH_W'(v);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
    assign ch_keep[i] = s_axis_tkeep[i*KEEP_W +: KEEP_W];
    assign pkt_cnt[i*32 +: 32] = cnt_q[i];
  end

  assign full = sk_cnt == 2'd2;
  assign m_axis_tvalid = sk_cnt != 2'd0;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata = sk_data[sk_rd];
  assign m_axis_tkeep = sk_keep[sk_rd];
  assign m_axis_tlast = sk_last[sk_rd];
  assign m_axis_tid = sk_id[sk_rd];
  assign sel_valid = s_axis_tvalid[grant_ch];
  assign sel_last = s_axis_tlast[grant_ch];
  assign acc = state == XFER && sel_valid && !full;
  assign to_hit = state == XFER && !sel_valid && timeout_cyc != '0 && to_cnt == timeout_cyc - TO_W'(1);
  assign pkt_end = sel_valid && sel_last && (acc || state == FLUSH);
  assign busy = state != IDLE || m_axis_tvalid;

  // Descending scan so the channel closest to ptr wins.
  always_comb begin
    hit = 1'b0;
    pick = ptr;
    cand = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = wrap({1'b0, ptr} + (CH_W+1)'(k));
      if (ch_enable[cand] && s_axis_tvalid[cand]) begin
        hit = 1'b1;
        pick = cand;
      end
    end
  end

  always_ff @(posedge sys_clk) state <= !sys_rst_n ? IDLE : state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = XFER;
      XFER:    if (acc && sel_last) state_nxt = IDLE; else if (to_hit) state_nxt = TERM;
      TERM:    if (!full) state_nxt = FLUSH;
      FLUSH:   if (pkt_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    s_axis_tready[grant_ch] = (state == XFER && !full) || state == FLUSH;
    push = acc || (state == TERM && !full);
    push_data = state == TERM ? '0 : ch_data[grant_ch];
    push_keep = state == TERM ? '0 : ch_keep[grant_ch];
  end

  // Two-entry FIFO: head register drives m_axis, second slot absorbs one beat of backpressure.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < 2; k++) begin
        sk_data[k] <= '0;
        sk_keep[k] <= '0;
        sk_id[k] <= '0;
      end
      sk_last <= '0;
      sk_wr <= 1'b0;
      sk_rd <= 1'b0;
      sk_cnt <= '0;
    end else begin
      if (push) begin
        sk_data[sk_wr] <= push_data;
        sk_keep[sk_wr] <= push_keep;
        sk_last[sk_wr] <= state == TERM || sel_last;
        sk_id[sk_wr] <= grant_ch;
        sk_wr <= ~sk_wr;
      end
      if (pop) sk_rd <= ~sk_rd;
      sk_cnt <= sk_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      grant_ch <= '0;
      ptr <= '0;
      to_cnt <= '0;
      timeout_err <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      if (state == IDLE && hit) grant_ch <= pick;
      if (pkt_end) ptr <= wrap({1'b0, grant_ch} + (CH_W+1)'(1));
      if (state != XFER || acc) to_cnt <= '0;
      else if (!sel_valid && timeout_cyc != '0) to_cnt <= to_cnt + TO_W'(1);
      if (acc && sel_last) cnt_q[grant_ch] <= cnt_q[grant_ch] + 32'd1;
      timeout_err <= (err_clr ? '0 : timeout_err) | (to_hit ? (NUM_CH'(1) << grant_ch) : '0);
    end
  end
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb_axis_frame_arbiter: directed bench for a 2-channel, 64-bit arbiter; one cycle per tick(),
// inputs driven on the falling edge, outputs sampled 2 time units later.
module tb_axis_frame_arbiter;
  typedef struct {logic b; logic l; logic [63:0] d;} src_t;
  typedef struct {logic [63:0] d; logic [7:0] k; logic l; logic id; int cyc;} beat_t;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, m_r = 1'b1, rnd = 1'b0;
  logic [1:0] en = 2'b11;
  logic [31:0] to = '0;
  logic [63:0] sd [2];
  logic [1:0] sv = '0, sl = '0, s_rdy, fire = '0;
  logic [127:0] s_data;
  logic [15:0] s_keep = 16'hFFFF;
  logic [63:0] m_d, pcnt;
  logic [7:0] m_k;
  logic m_l, m_id, m_v, grant, busy, hold = 1'b0, rdy0_seen = 1'b0;
  logic [1:0] terr;
  logic [73:0] saved = '0;
  src_t sq [2][$];
  beat_t outq[$];
  int acc_cyc[$];
  int cyc = 0, n_chk = 0, n_fail = 0;

  assign s_data = {sd[1], sd[0]};
  always #5 clk = ~clk;

  axis_frame_arbiter #(.NUM_CH(2), .DATA_W(64)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .ch_enable(en), .timeout_cyc(to), .err_clr(clr),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(sl), .s_axis_tvalid(sv),
    .s_axis_tready(s_rdy), .m_axis_tdata(m_d), .m_axis_tkeep(m_k), .m_axis_tlast(m_l),
    .m_axis_tid(m_id), .m_axis_tvalid(m_v), .m_axis_tready(m_r), .grant_ch(grant),
    .busy(busy), .timeout_err(terr), .pkt_cnt(pcnt)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int c, input int n, input logic [63:0] base, input logic last_at_end);
    for (int j = 0; j < n; j++) sq[c].push_back('{1'b0, last_at_end && j == n - 1, base + 64'(j)});
  endtask

  task automatic bubbles(input int c, input int n);
    for (int j = 0; j < n; j++) sq[c].push_back('{1'b1, 1'b0, 64'd0});
  endtask

  // Bubble entries hold tvalid low for exactly one cycle; beats wait for a handshake.
  task automatic tick();
    if (rnd) m_r = 1'($urandom_range(0, 1));
    for (int c = 0; c < 2; c++) begin
      sv[c] = sq[c].size() > 0 && !sq[c][0].b;
      sl[c] = sq[c].size() > 0 && sq[c][0].l;
      sd[c] = sq[c].size() > 0 ? sq[c][0].d : 64'd0;
    end
    #2;
    fire = sv & s_rdy & {2{rst_n}};
    if (fire != 2'b00) acc_cyc.push_back(cyc);
    if (s_rdy[0]) rdy0_seen = 1'b1;
    if (hold) begin
      chk("hold_valid", 80'(m_v), 80'(1));
      chk("hold_beat", 80'({m_id, m_l, m_k, m_d}), 80'(saved));
    end
    hold = m_v && !m_r && rst_n;
    saved = {m_id, m_l, m_k, m_d};
    if (m_v && m_r && rst_n) outq.push_back('{m_d, m_k, m_l, m_id, cyc});
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 2; c++)
      if (sq[c].size() > 0 && (sq[c][0].b || fire[c])) void'(sq[c].pop_front());
  endtask

  initial begin
    sd[0] = '0;
    sd[1] = '0;
    @(negedge clk);
    repeat (2) tick();
    chk("rst_m_valid", 80'(m_v), 80'(0));
    chk("rst_m_beat", 80'({m_id, m_l, m_k, m_d}), 80'(0));
    chk("rst_s_ready", 80'(s_rdy), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_grant", 80'(grant), 80'(0));
    chk("rst_err", 80'(terr), 80'(0));
    chk("rst_pkt_cnt", 80'(pcnt), 80'(0));
    rst_n = 1'b1;
    tick();

    // single 4-beat packet on ch0
    outq.delete();
    acc_cyc.delete();
    load(0, 4, 64'hA0, 1'b1);
    repeat (8) tick();
    chk("t1_beats", 80'(outq.size()), 80'(4));
    for (int j = 0; j < outq.size(); j++) begin
      chk("t1_data", 80'(outq[j].d), 80'(64'hA0 + 64'(j)));
      chk("t1_tid_keep", 80'({outq[j].id, outq[j].k}), 80'({1'b0, 8'hFF}));
      chk("t1_last", 80'(outq[j].l), 80'(j == 3));
    end
    if (outq.size() > 0 && acc_cyc.size() > 0) chk("t1_latency", 80'(outq[0].cyc - acc_cyc[0]), 80'(1));
    chk("t1_pkt_cnt0", 80'(pcnt[31:0]), 80'(1));
    chk("t1_busy", 80'(busy), 80'(0));

    // round-robin: three 3-beat packets per channel, pointer restarted at 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    outq.delete();
    for (int p = 0; p < 3; p++) begin
      load(0, 3, 64'h100 + 64'(p * 16), 1'b1);
      load(1, 3, 64'h200 + 64'(p * 16), 1'b1);
    end
    repeat (30) tick();
    chk("t2_beats", 80'(outq.size()), 80'(18));
    for (int j = 0; j < outq.size(); j++) begin
      chk("t2_tid", 80'(outq[j].id), 80'((j / 3) % 2));
      chk("t2_data", 80'(outq[j].d), 80'((((j / 3) % 2) == 1 ? 64'h200 : 64'h100) + 64'((j / 6) * 16 + j % 3)));
      chk("t2_last", 80'(outq[j].l), 80'(j % 3 == 2));
    end
    chk("t2_pkt_cnt", 80'(pcnt), 80'({32'd3, 32'd3}));

    // 16-beat packet under random backpressure
    outq.delete();
    load(0, 16, 64'd0, 1'b1);
    rnd = 1'b1;
    for (int i = 0; i < 300 && outq.size() < 16; i++) tick();
    rnd = 1'b0;
    m_r = 1'b1;
    repeat (3) tick();
    chk("t3_beats", 80'(outq.size()), 80'(16));
    for (int j = 0; j < outq.size(); j++) begin
      chk("t3_data", 80'(outq[j].d), 80'(j));
      chk("t3_last", 80'(outq[j].l), 80'(j == 15));
    end
    chk("t3_pkt_cnt0", 80'(pcnt[31:0]), 80'(4));

    // stall timeout on ch1
    to = 32'd10;
    outq.delete();
    acc_cyc.delete();
    load(1, 2, 64'h10, 1'b0);
    bubbles(1, 12);
    load(1, 3, 64'h20, 1'b1);
    repeat (22) tick();
    chk("t4_beats", 80'(outq.size()), 80'(3));
    if (outq.size() == 3) begin
      chk("t4_beat0", 80'({outq[0].id, outq[0].l, outq[0].d}), 80'({1'b1, 1'b0, 64'h10}));
      chk("t4_beat1", 80'({outq[1].id, outq[1].l, outq[1].d}), 80'({1'b1, 1'b0, 64'h11}));
      chk("t4_term", 80'({outq[2].id, outq[2].l, outq[2].k, outq[2].d}), 80'({1'b1, 1'b1, 8'h00, 64'h0}));
      if (acc_cyc.size() > 1) chk("t4_term_time", 80'(outq[2].cyc - acc_cyc[1]), 80'(12));
    end
    chk("t4_err", 80'(terr), 80'(2'b10));
    chk("t4_pkt_cnt1", 80'(pcnt[63:32]), 80'(3));
    chk("t4_flushed", 80'(sq[1].size()), 80'(0));
    chk("t4_busy", 80'(busy), 80'(0));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_err_clr", 80'(terr), 80'(0));

    // enable masking: ch0 held off until ch1's packet ends
    to = '0;
    en = 2'b10;
    outq.delete();
    rdy0_seen = 1'b0;
    load(0, 3, 64'h300, 1'b1);
    load(1, 4, 64'h400, 1'b1);
    repeat (2) tick();
    en = 2'b11;
    repeat (4) tick();
    chk("t5_ch0_masked", 80'(rdy0_seen), 80'(0));
    repeat (8) tick();
    chk("t5_beats", 80'(outq.size()), 80'(7));
    for (int j = 0; j < outq.size(); j++) begin
      chk("t5_tid", 80'(outq[j].id), 80'(j < 4));
      chk("t5_data", 80'(outq[j].d), 80'(j < 4 ? 64'h400 + 64'(j) : 64'h300 + 64'(j - 4)));
    end

    // reset during beat 3 of 8; pointer was 1 before reset
    outq.delete();
    load(0, 8, 64'h500, 1'b1);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_m_valid", 80'(m_v), 80'(0));
    chk("t6_m_beat", 80'({m_id, m_l, m_k, m_d}), 80'(0));
    chk("t6_s_ready", 80'(s_rdy), 80'(0));
    chk("t6_state", 80'({busy, grant, terr}), 80'(0));
    chk("t6_pkt_cnt", 80'(pcnt), 80'(0));
    chk("t6_pre_beats", 80'(outq.size()), 80'(2));
    sq[0].delete();
    rst_n = 1'b1;
    outq.delete();
    load(0, 1, 64'h600, 1'b1);
    load(1, 1, 64'h700, 1'b1);
    repeat (8) tick();
    chk("t6_beats", 80'(outq.size()), 80'(2));
    if (outq.size() == 2) begin
      chk("t6_first", 80'({outq[0].id, outq[0].l, outq[0].k, outq[0].d}), 80'({1'b0, 1'b1, 8'hFF, 64'h600}));
      chk("t6_second", 80'({outq[1].id, outq[1].l, outq[1].k, outq[1].d}), 80'({1'b1, 1'b1, 8'hFF, 64'h700}));
    end
    chk("t6_pkt_cnt", 80'(pcnt), 80'({32'd1, 32'd1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Parametrised N-channel AXI-Stream packet arbiter that merges several capture sources (camera link, X-band loopback, future sensors) onto one DMA S2MM stream port.
- Grants whole packets (tlast-delimited) round-robin among enabled channels. Tags each output beat with its source channel.
- Provides a per-channel stall timeout with forced packet termination, plus sticky error flags and per-channel packet counters for the AXI4-Lite register bank.

Parameters:
- NUM_CH, 2, number of input channels (2..8).
- DATA_W, 64, tdata width in bits; multiple of 8.
- KEEP_W, DATA_W/8, tkeep width.
- CH_W, $clog2(NUM_CH) (minimum 1), width of the channel index.
- TO_W, 32, width of the timeout counter.

Ports:
- sys_clk, in, 1, single clock for the whole block.
- sys_rst_n, in, 1, synchronous active-low reset.
- ch_enable, in, NUM_CH, per-channel arbitration enable.
- timeout_cyc, in, TO_W, mid-packet stall limit in cycles; 0 disables the timeout.
- err_clr, in, 1, single-cycle pulse that clears every bit of timeout_err.
- s_axis_tdata, in, NUM_CH*DATA_W, flattened; channel i occupies [i*DATA_W +: DATA_W].
- s_axis_tkeep, in, NUM_CH*KEEP_W, flattened the same way.
- s_axis_tlast, in, NUM_CH, per-channel tlast.
- s_axis_tvalid, in, NUM_CH, per-channel tvalid.
- s_axis_tready, out, NUM_CH, per-channel tready.
- m_axis_tdata, out, DATA_W, merged output data.
- m_axis_tkeep, out, KEEP_W, merged output keep.
- m_axis_tlast, out, 1, merged output tlast.
- m_axis_tid, out, CH_W, source channel of the current output beat.
- m_axis_tvalid, out, 1, merged output valid.
- m_axis_tready, in, 1, downstream ready.
- grant_ch, out, CH_W, currently or most recently granted channel.
- busy, out, 1, high while not in IDLE.
- timeout_err, out, NUM_CH, sticky per-channel timeout flags.
- pkt_cnt, out, NUM_CH*32, per-channel completed-packet counters (wrapping).

Behaviour:
- Reset (sys_rst_n=0 at a rising edge of sys_clk):
  - state to IDLE; skid buffer empties.
  - All outputs go to 0: m_axis_*, s_axis_tready, busy, grant_ch, timeout_err, pkt_cnt.
  - Round-robin pointer goes to 0.
  - Reset mid-packet abandons the packet; no terminating beat is emitted.
- Output stage:
  - 2-entry skid buffer drives m_axis_*.
  - An input beat accepted in cycle N appears on m_axis with tvalid=1 in cycle N+1.
  - Full throughput: 1 beat/cycle when m_axis_tready is held 1.
  - Once m_axis_tvalid=1, m_axis data is held stable until m_axis_tready=1.
- s_axis_tready[i] = (state==XFER) && (grant==i) && skid not full. All other channels see 0.
- State IDLE:
  - Search order: ptr, ptr+1, … modulo NUM_CH.
  - Select the first channel with ch_enable[i] && s_axis_tvalid[i].
  - On a hit: grant_ch<=i, go to XFER; the first beat can be accepted in the next cycle.
  - The IDLE-to-XFER decision costs 1 idle cycle between packets.
- State XFER:
  - Pass beats from the granted channel.
  - On an accepted beat with tlast=1: pkt_cnt[grant]++, ptr<=grant+1 (modulo NUM_CH), go to IDLE.
  - ch_enable changes have no effect on a packet in progress; they apply at the next IDLE.
- Timeout (active only in XFER, and only when timeout_cyc≠0):
  - The counter increments each cycle that s_axis_tvalid[grant]=0.
  - It clears on every accepted beat and on entry to XFER.
  - Backpressure cycles (skid full) do not count.
  - When the counter reaches timeout_cyc: set timeout_err[grant], go to TERM.
- State TERM:
  - Push one terminating beat into the skid: tdata=0, tkeep=0, tlast=1, tid=grant.
  - Wait for skid space if full; then go to FLUSH.
  - pkt_cnt is not incremented for a terminated packet.
- State FLUSH:
  - s_axis_tready[grant]=1; beats are discarded and not forwarded.
  - On an accepted tlast: ptr<=grant+1, go to IDLE.
- timeout_err:
  - Set has priority over err_clr in the same cycle for that channel.
  - err_clr clears all other bits.
- pkt_cnt wraps from 0xFFFFFFFF to 0 with no flag.
- busy = (state≠IDLE) || m_axis_tvalid.
- Channel with ch_enable=0 and tvalid=1 stays stalled (tready=0) indefinitely; no error is raised.
- Single-beat packet (tlast on the first beat): valid; counted once.

Test Plan:
- NUM_CH=2, timeout_cyc=0, m_axis_tready=1:
  - ch0 sends 4 beats, last with tlast; ch1 idle.
  - Expect 4 m_axis beats, tid=0, first beat 1 cycle after s-side accept, pkt_cnt[0]=1.
- Round-robin fairness:
  - Both channels continuously valid with 3-beat packets; run 6 packets.
  - Expect grant order 0,1,0,1,0,1; pkt_cnt[0]=pkt_cnt[1]=3; no interleaving inside a packet.
- Backpressure:
  - Toggle m_axis_tready randomly at 50% for a 16-beat packet with tdata=beat index.
  - Expect data 0..15 in order, none dropped or duplicated, m_axis held stable while tready=0.
- Timeout:
  - timeout_cyc=10; ch1 sends 2 beats, then tvalid=0 for 12 cycles, then 3 more beats ending in tlast.
  - Expect a terminating beat (tkeep=0, tlast=1, tid=1) after 10 stall cycles.
  - Expect timeout_err=2'b10, the 3 late beats discarded, pkt_cnt[1] unchanged.
  - Then pulse err_clr; expect timeout_err=0.
- Enable masking:
  - ch_enable=2'b10 with both channels valid.
  - Expect only ch1 granted and ch0 tready=0 throughout.
  - Set ch_enable=2'b11 mid-packet; expect ch0 granted only after ch1's tlast.
- Reset:
  - Assert sys_rst_n=0 for 1 cycle during beat 3 of 8.
  - Expect all outputs 0 the next cycle, no terminating beat, and the next packet to arbitrate from ptr=0.
